// File: rtl/fastpath_bp_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : fastpath_bp_pipe_if
// Purpose  : Fetch-side request / resolve-side outcome bundle for the
//            fast-path perceptron predictor pipeline.
// Revision : 1.0
// ============================================================================
interface fastpath_bp_pipe_if #(
    parameter int PC_WIDTH = 64,
    parameter int DEPTH    = 8
);
    logic                       req_valid;
    logic [PC_WIDTH-1:0]        req_pc;
    logic                       req_ready;
    logic                       pred_valid;
    logic                       pred_taken;
    logic [$clog2(DEPTH)-1:0]   pred_tag;
    logic                       res_valid;
    logic                       res_taken;
    logic                       res_mispredict;
    logic                       res_error;
    logic [$clog2(DEPTH):0]     occupancy;

    modport master (
        output req_valid, req_pc, res_valid, res_taken,
        input  req_ready, pred_valid, pred_taken, pred_tag,
               res_mispredict, res_error, occupancy
    );

    modport slave (
        input  req_valid, req_pc, res_valid, res_taken,
        output req_ready, pred_valid, pred_taken, pred_tag,
               res_mispredict, res_error, occupancy
    );
endinterface
`default_nettype wire

// File: rtl/fastpath_bp_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fastpath_bp_pipe
// Purpose  : Single-table fast-path perceptron predictor with an in-order
//            checkpointed in-flight queue and mispredict recovery.
// Revision : 1.0
// ============================================================================
module fastpath_bp_pipe #(
    parameter int WEIGHT_WIDTH = 8,
    parameter int HIST_LEN     = 16,
    parameter int ENTRIES      = 64,
    parameter int PC_WIDTH     = 64,
    parameter int PC_LSB       = 2,
    parameter int DEPTH        = 8,
    parameter int THETA        = 44
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    fastpath_bp_pipe_if.slave bus
);
    localparam int c_idx_w = $clog2(ENTRIES);
    localparam int c_sum_w = WEIGHT_WIDTH + $clog2(HIST_LEN + 1) + 1;
    localparam int c_ptr_w = $clog2(DEPTH);

    typedef logic [WEIGHT_WIDTH-1:0]                  weight_t;
    typedef logic [HIST_LEN:0][WEIGHT_WIDTH-1:0]      row_t;
    typedef logic [HIST_LEN:0][c_sum_w-1:0]           sr_t;
    typedef logic [HIST_LEN-1:0][c_sum_w-1:0]         ckpt_t;
    typedef logic [HIST_LEN-1:0][c_idx_w-1:0]         path_t;

    typedef struct packed {
        logic [c_idx_w-1:0]  idx;
        logic [c_sum_w-1:0]  y;
        logic                p;
        ckpt_t               sr;
        logic [HIST_LEN-1:0] hist;
        path_t               path;
    } entry_t;

    localparam weight_t                   c_w_one   = weight_t'(1);
    localparam weight_t                   c_w_max   = {1'b0, {(WEIGHT_WIDTH-1){1'b1}}};
    localparam weight_t                   c_w_min   = {1'b1, {(WEIGHT_WIDTH-1){1'b0}}};
    localparam logic signed [c_sum_w-1:0] c_theta   = c_sum_w'(THETA);
    localparam logic signed [c_sum_w-1:0] c_ntheta  = -c_theta;
    localparam logic [c_ptr_w-1:0]        c_ptr_one = c_ptr_w'(1);
    localparam logic [c_ptr_w:0]          c_cnt_one = (c_ptr_w + 1)'(1);
    localparam logic [c_ptr_w:0]          c_cnt_max = (c_ptr_w + 1)'(DEPTH);

    function automatic logic [c_sum_w-1:0] f_sext(input weight_t v);
        return {{(c_sum_w - WEIGHT_WIDTH){v[WEIGHT_WIDTH-1]}}, v};
    endfunction

    // One fast-path step: every partial sum moves one slot up and absorbs
    // its column weight, signed by the direction being committed.
    function automatic sr_t f_advance(input ckpt_t base, input row_t row, input logic dir);
        sr_t nx;
        nx[0] = '0;
        for (int j = 1; j <= HIST_LEN; j++) begin
            nx[j] = dir ? base[j-1] + f_sext(row[j]) : base[j-1] - f_sext(row[j]);
        end
        return nx;
    endfunction

    function automatic weight_t f_sat_step(input weight_t v, input logic up);
        if (up) begin
            return (v == c_w_max) ? v : v + c_w_one;
        end
        return (v == c_w_min) ? v : v - c_w_one;
    endfunction

    row_t                r_w [ENTRIES];
    sr_t                 r_sr;
    logic [HIST_LEN-1:0] r_hist;
    path_t               r_path;
    entry_t              r_q [DEPTH];
    logic [c_ptr_w-1:0]  r_head;
    logic [c_ptr_w-1:0]  r_tail;
    logic [c_ptr_w:0]    r_count;
    logic                r_run;
    logic                r_pred_valid;
    logic                r_pred_taken;
    logic [c_ptr_w-1:0]  r_pred_tag;
    logic                r_mispredict;
    logic                r_error;

    logic [c_idx_w-1:0]         w_idx;
    row_t                       w_row;
    logic [c_sum_w-1:0]         w_y;
    logic                       w_p;
    entry_t                     w_head;
    entry_t                     w_new;
    logic signed [c_sum_w-1:0]  w_head_y;
    logic                       w_nonempty;
    logic                       w_pop;
    logic                       w_mispred;
    logic                       w_ready;
    logic                       w_push;
    logic                       w_train;

    assign w_idx      = c_idx_w'(bus.req_pc >> PC_LSB);
    assign w_row      = r_w[w_idx];
    assign w_y        = r_sr[HIST_LEN] + f_sext(w_row[0]);
    assign w_p        = ~w_y[c_sum_w-1];
    assign w_head     = r_q[r_head];
    assign w_head_y   = w_head.y;
    assign w_nonempty = (r_count != '0);
    assign w_pop      = bus.res_valid && w_nonempty;
    assign w_mispred  = w_pop && (bus.res_taken != w_head.p);
    // A full queue refuses even when a pop frees a slot in the same cycle.
    assign w_ready    = r_run && (r_count != c_cnt_max) && !w_mispred;
    assign w_push     = bus.req_valid && w_ready;
    assign w_train    = w_pop && (w_mispred || ((w_head_y <= c_theta) && (w_head_y >= c_ntheta)));
    assign w_new      = '{idx: w_idx, y: w_y, p: w_p, sr: r_sr[HIST_LEN-1:0],
                          hist: r_hist, path: r_path};

    assign bus.req_ready      = w_ready;
    assign bus.pred_valid     = r_pred_valid;
    assign bus.pred_taken     = r_pred_taken;
    assign bus.pred_tag       = r_pred_tag;
    assign bus.res_mispredict = r_mispredict;
    assign bus.res_error      = r_error;
    assign bus.occupancy      = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q[r_tail] <= w_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < ENTRIES; e++) begin
                r_w[e] <= '0;
            end
            r_sr         <= '0;
            r_hist       <= '0;
            r_path       <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_run        <= 1'b0;
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_pred_tag   <= '0;
            r_mispredict <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_run        <= 1'b1;
            r_pred_valid <= w_push;
            r_pred_taken <= w_push && w_p;
            r_pred_tag   <= w_push ? r_tail : '0;
            r_mispredict <= w_mispred;
            r_error      <= bus.res_valid && !w_nonempty;

            // Column j is touched only by the path entry j branches back,
            // so every column sees at most one write per edge.
            if (w_train) begin
                r_w[w_head.idx][0] <= f_sat_step(r_w[w_head.idx][0], bus.res_taken);
                for (int j = 1; j <= HIST_LEN; j++) begin
                    r_w[w_head.path[j-1]][j] <= f_sat_step(r_w[w_head.path[j-1]][j],
                                                           bus.res_taken == w_head.hist[j-1]);
                end
            end

            if (w_mispred) begin
                r_sr    <= f_advance(w_head.sr, r_w[w_head.idx], bus.res_taken);
                r_hist  <= {w_head.hist[HIST_LEN-2:0], bus.res_taken};
                r_path  <= {w_head.path[HIST_LEN-2:0], w_head.idx};
                r_head  <= r_head + c_ptr_one;
                r_tail  <= r_head + c_ptr_one;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_sr   <= f_advance(r_sr[HIST_LEN-1:0], w_row, w_p);
                    r_hist <= {r_hist[HIST_LEN-2:0], w_p};
                    r_path <= {r_path[HIST_LEN-2:0], w_idx};
                    r_tail <= r_tail + c_ptr_one;
                end
                if (w_pop) begin
                    r_head <= r_head + c_ptr_one;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + c_cnt_one;
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - c_cnt_one;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fastpath_bp_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fastpath_bp_pipe
// Purpose  : Directed self-checking bench for fastpath_bp_pipe (4-bit weights
//            so that both saturation rails are reachable in a short run).
// Revision : 1.0
// ============================================================================
module tb_fastpath_bp_pipe;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    fastpath_bp_pipe_if #(.PC_WIDTH(64), .DEPTH(8)) bus ();

    fastpath_bp_pipe #(
        .WEIGHT_WIDTH(4),
        .HIST_LEN(16),
        .ENTRIES(64),
        .PC_WIDTH(64),
        .PC_LSB(2),
        .DEPTH(8),
        .THETA(44)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.res_valid = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_pc    = '0;
        bus.res_valid = 1'b0;
        bus.res_taken = 1'b0;
        tick;
        tick;
        chk("rst_pred_valid", bus.pred_valid, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_occupancy", bus.occupancy, 0);
        chk("rst_mispredict", bus.res_mispredict, 0);
        chk("rst_error", bus.res_error, 0);
        rst_n = 1'b1;
        tick;
        chk("ready_after_release", bus.req_ready, 1);

        // Test 1: first prediction on zero weights, correct resolve trains.
        bus.req_valid = 1'b1;
        bus.req_pc    = 64'h40;
        tick;
        bus.req_valid = 1'b0;
        chk("t1_pred_valid", bus.pred_valid, 1);
        chk("t1_pred_taken", bus.pred_taken, 1);
        chk("t1_pred_tag", bus.pred_tag, 0);
        chk("t1_occupancy", bus.occupancy, 1);
        bus.res_valid = 1'b1;
        bus.res_taken = 1'b1;
        tick;
        bus.res_valid = 1'b0;
        chk("t1_w16_0", dut.r_w[16][0], 64'h1);
        chk("t1_w0_1", dut.r_w[0][1], 64'hF);
        chk("t1_mispredict", bus.res_mispredict, 0);
        chk("t1_occ_after", bus.occupancy, 0);

        // Test 2: always not-taken on row 0; bias and columns hit the rails.
        do_reset;
        for (int n = 1; n <= 200; n++) begin
            bus.req_valid = 1'b1;
            bus.req_pc    = 64'h100;
            tick;
            bus.req_valid = 1'b0;
            chk("t2_pred_taken", bus.pred_taken, (n == 1) ? 1 : 0);
            bus.res_valid = 1'b1;
            bus.res_taken = 1'b0;
            tick;
            bus.res_valid = 1'b0;
        end
        chk("t2_w0_0_min", dut.r_w[0][0], 64'h8);
        chk("t2_w0_1_max", dut.r_w[0][1], 64'h7);
        chk("t2_w0_16_max", dut.r_w[0][16], 64'h7);
        chk("t2_occupancy", bus.occupancy, 0);

        // Test 3: fill the queue, refused 9th request, pop/push interplay.
        do_reset;
        bus.req_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.req_pc = 64'(k * 4);
            tick;
            chk("t3_fill_tag", bus.pred_tag, k);
        end
        chk("t3_full_occ", bus.occupancy, 8);
        chk("t3_full_ready", bus.req_ready, 0);
        tick;
        chk("t3_ninth_no_pred", bus.pred_valid, 0);
        chk("t3_ninth_occ", bus.occupancy, 8);
        bus.res_valid = 1'b1;
        bus.res_taken = 1'b1;
        #1;
        chk("t3_full_pop_ready", bus.req_ready, 0);
        tick;
        chk("t3_pop_only_occ", bus.occupancy, 7);
        chk("t3_pop_only_pred", bus.pred_valid, 0);
        chk("t3_pop_push_ready", bus.req_ready, 1);
        tick;
        bus.res_valid = 1'b0;
        bus.req_valid = 1'b0;
        chk("t3_pop_push_occ", bus.occupancy, 7);
        chk("t3_pop_push_tag", bus.pred_tag, 0);

        // Test 4: mispredict recovery from a checkpoint with live weights.
        do_reset;
        bus.req_valid = 1'b1;
        bus.req_pc    = 64'h0;
        tick;
        bus.req_valid = 1'b0;
        chk("t4_p0_taken", bus.pred_taken, 1);
        bus.res_valid = 1'b1;
        bus.res_taken = 1'b0;
        tick;
        bus.res_valid = 1'b0;
        chk("t4_p0_mispredict", bus.res_mispredict, 1);
        bus.req_valid = 1'b1;
        bus.req_pc    = 64'h0;
        tick;
        chk("t4_r1_taken", bus.pred_taken, 0);
        chk("t4_r1_tag", bus.pred_tag, 1);
        bus.req_pc = 64'h8;
        tick;
        chk("t4_r2_taken", bus.pred_taken, 0);
        bus.req_pc = 64'hC;
        tick;
        chk("t4_r3_tag", bus.pred_tag, 3);
        chk("t4_occ3", bus.occupancy, 3);
        bus.req_pc    = 64'h0;
        bus.res_valid = 1'b1;
        bus.res_taken = 1'b1;
        #1;
        chk("t4_no_accept_on_mispredict", bus.req_ready, 0);
        tick;
        bus.res_valid = 1'b0;
        chk("t4_mispredict", bus.res_mispredict, 1);
        chk("t4_occ_flushed", bus.occupancy, 0);
        chk("t4_blocked_pred", bus.pred_valid, 0);
        chk("t4_sr0", dut.r_sr[0], 0);
        chk("t4_sr1", dut.r_sr[1], 1);
        chk("t4_sr16", dut.r_sr[16], 1);
        tick;
        bus.req_valid = 1'b0;
        chk("t4_next_taken", bus.pred_taken, 1);
        chk("t4_next_tag", bus.pred_tag, 2);
        chk("t4_next_sr1", dut.r_sr[1], 0);
        chk("t4_next_sr2", dut.r_sr[2], 1);
        chk("t4_next_hist", dut.r_hist[1:0], 2'b11);
        chk("t4_mispredict_cleared", bus.res_mispredict, 0);

        // Test 5: drain, then resolve with nothing in flight.
        bus.res_valid = 1'b1;
        bus.res_taken = 1'b1;
        tick;
        chk("t5_drain_mispredict", bus.res_mispredict, 0);
        chk("t5_drain_w0_0", dut.r_w[0][0], 64'h1);
        tick;
        bus.res_valid = 1'b0;
        chk("t5_error", bus.res_error, 1);
        chk("t5_occ", bus.occupancy, 0);
        chk("t5_w0_0_kept", dut.r_w[0][0], 64'h1);
        chk("t5_w0_1_kept", dut.r_w[0][1], 64'h1);
        chk("t5_w0_2_kept", dut.r_w[0][2], 64'hF);
        tick;
        chk("t5_error_pulse", bus.res_error, 0);

        // Test 6: asynchronous reset with five branches in flight.
        bus.req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.req_pc = 64'h40 + 64'(k * 4);
            tick;
        end
        bus.req_valid = 1'b0;
        chk("t6_occ5", bus.occupancy, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_occ", bus.occupancy, 0);
        chk("t6_async_pred_valid", bus.pred_valid, 0);
        chk("t6_async_ready", bus.req_ready, 0);
        tick;
        rst_n = 1'b1;
        tick;
        bus.req_valid = 1'b1;
        bus.req_pc    = 64'h200;
        tick;
        bus.req_valid = 1'b0;
        chk("t6_first_taken", bus.pred_taken, 1);
        chk("t6_first_tag", bus.pred_tag, 0);
        chk("t6_first_occ", bus.occupancy, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
